// File: rtl/reg_dump_reader.sv
// reg_dump_reader: debug read-out engine for the 8-bit register file.
// On start it walks addresses 0..2**PW-1 via rd_addr, captures each read and
// streams the bytes over a valid/ready interface, holding busy so the core
// keeps the register contents frozen.
// Optional feature macro: REG_DUMP_CHECKSUM_EN appends an XOR checksum byte.
module reg_dump_reader #(
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [PW:0]   rd_addr,
  input  logic [7:0]    rd_data,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
`ifdef REG_DUMP_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  localparam logic [PW-1:0] IDX_MAX = '1;

  state_t        state;
  logic [PW-1:0] idx;
  logic [PW-1:0] idx_nxt;
  logic          hs;

  assign hs      = out_valid & out_ready;
  assign idx_nxt = idx + 1'b1;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0] csum;

  // running XOR of every accepted register byte
  always_ff @(posedge clk) begin
    if (reset)
      csum <= '0;
    else if (state == IDLE && start)
      csum <= '0;
    else if (state == SEND && hs)
      csum <= csum ^ out_data;
  end
`endif

  // dump sequencer: all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      rd_addr   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx     <= '0;
            rd_addr <= '0;
            busy    <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          out_data  <= rd_data;
          out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
`else
          out_last  <= (idx == IDX_MAX);
`endif
          state     <= SEND;
        end
        SEND: begin
          if (hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (idx != IDX_MAX) begin
              idx     <= idx_nxt;
              rd_addr <= {1'b0, idx_nxt};
              state   <= READ;
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              // final checksum includes the byte being accepted now
              out_data  <= csum ^ out_data;
              out_valid <= 1'b1;
              out_last  <= 1'b1;
              state     <= CSUM;
`else
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
`endif
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        CSUM: begin
          if (hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          // start here is deliberately ignored
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader with PW=3 and regs {01,02,...,80}.
module tb_reg_dump_reader;

  localparam int PW = 3;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [PW:0]   rd_addr;
  logic [7:0]    rd_data;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [7:0]    regs [8];

  int passed = 0;
  int total  = 0;

  reg_dump_reader #(.PW(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign rd_data = rd_addr[PW] ? 8'hEE : regs[rd_addr[PW-1:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_addr"},  32'(rd_addr),   0);
    chk({tag, "_data"},  32'(out_data),  0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_last"},  32'(out_last),  0);
    chk({tag, "_busy"},  32'(busy),      0);
    chk({tag, "_done"},  32'(done),      0);
  endtask

  // Issues start, then expects the full stream; ends in the DONE cycle.
  // stall_idx: byte held under out_ready=0 for 5 cycles; start_idx: byte
  // during which a stray start is pulsed (-1 disables either).
  task automatic dump(input string tag, input int stall_idx, input int start_idx);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_rd_busy"},  32'(busy),      1);
    chk({tag, "_rd_valid"}, 32'(out_valid), 0);
    chk({tag, "_rd_addr0"}, 32'(rd_addr),   0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_b%0d_valid", tag, i), 32'(out_valid), 1);
      chk($sformatf("%s_b%0d_data", tag, i),  32'(out_data),  32'(regs[i]));
      chk($sformatf("%s_b%0d_last", tag, i),  32'(out_last),  32'(i == 7 && !CS));
      chk($sformatf("%s_b%0d_addr", tag, i),  32'(rd_addr),   32'(i));
      chk($sformatf("%s_b%0d_done", tag, i),  32'(done),      0);
      if (i == stall_idx) begin
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          chk($sformatf("%s_stall%0d_valid", tag, k), 32'(out_valid), 1);
          chk($sformatf("%s_stall%0d_data", tag, k),  32'(out_data),  32'(regs[i]));
          chk($sformatf("%s_stall%0d_addr", tag, k),  32'(rd_addr),   32'(i));
        end
        out_ready = 1'b1;
      end
      if (i == start_idx) start = 1'b1;
      tick();
      start = 1'b0;
      if (i < 7 || CS) begin
        chk($sformatf("%s_b%0d_bubble", tag, i), 32'(out_valid), 32'(CS && i == 7));
        chk($sformatf("%s_b%0d_busy", tag, i),   32'(busy),      1);
        if (i < 7) tick();
      end
    end
    if (CS) begin
      chk({tag, "_cs_data"}, 32'(out_data), 32'h0FF);
      chk({tag, "_cs_last"}, 32'(out_last), 1);
      tick();
    end
    chk({tag, "_done"},       32'(done),      1);
    chk({tag, "_done_busy"},  32'(busy),      0);
    chk({tag, "_done_valid"}, 32'(out_valid), 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 8'(1 << i);

    // reset state
    tick(); tick();
    chk_idle_outputs("reset");
    reset = 1'b0;
    tick();
    chk_idle_outputs("idle");

    // 1/2 basic stream (with checksum byte when enabled)
    dump("basic", -1, -1);
    tick();
    chk("basic_done_drop", 32'(done), 0);
    chk("basic_idle_busy", 32'(busy), 0);

    // 3 backpressure on byte 08, 4 stray start during byte 04
    dump("bp", 3, 2);
    tick();
    chk("bp_single_done", 32'(done), 0);
    chk("bp_no_restart",  32'(busy), 0);

    // 5 reset after byte 02 accepted
    start = 1'b1; tick(); start = 1'b0;
    tick();                                   // byte 01 offered
    chk("rst_b0", 32'(out_data), 32'h01);
    tick(); tick();                           // byte 02 offered
    chk("rst_b1", 32'(out_data), 32'h02);
    tick();                                   // byte 02 accepted
    chk("rst_addr2", 32'(rd_addr), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle_outputs("midrst");
    tick();
    chk("midrst_nodone", 32'(done), 0);
    dump("after_rst", -1, -1);

    // 6 start held through DONE (ignored) into IDLE (accepted)
    start = 1'b1;
    tick();
    chk("b2b_done_ign_busy", 32'(busy),    0);
    chk("b2b_done_ign_addr", 32'(rd_addr), 7);
    dump("b2b", -1, -1);
    tick();
    chk("b2b_end_done", 32'(done), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
